// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Sequencing FSM for the multi-cycle RV32I core. One micro-step per clock;
//   decodes op/func3/func7 and the ALU flags into every datapath select and
//   enable of the shared-memory datapath, and raises done on the halt opcode.
//
// Parameters
//   BOOT_WAIT  idle cycles after reset release before the first FETCH (0..255)
//   OP_HALT    opcode that stops the core (HALT state, done=1)
//
// Optional feature
//   MULTICYCLE_ILLEGAL_TRAP_EN  when defined, an unknown opcode or an illegal
//   func3 on R/I-type ALU ops or branches traps to HALT from DECODE with
//   done=1 and illegal=1. When undefined, illegal is tied 0 and unknown
//   opcodes execute as a 2-cycle NOP.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-low reset
//   op, func3, func7   instruction fields from IR
//   zero, lt           ALU flags (result==0, signed rs1<rs2)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB                    datapath mux selects
//   ALUControl, ImmSrc                             ALU op / immediate format
//   done, illegal                                  halt status
//
// Outputs are decoded from the state register (plus IR fields / flags where
// the datapath needs them the same cycle) and forced to 0 while rst is low so
// no write fires in a reset cycle.
module multicycle_controller #(
  parameter int unsigned BOOT_WAIT = 0,
  parameter logic [6:0]  OP_HALT   = 7'b0000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       done,
  output logic       illegal
);

  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // 5-bit encoding leaves spare codes; any of them recovers to BOOT.
  typedef enum logic [4:0] {
    S_BOOT     = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_MEMADR   = 5'd3,
    S_MEMREAD  = 5'd4,
    S_MEMWB    = 5'd5,
    S_MEMWRITE = 5'd6,
    S_EXECR    = 5'd7,
    S_EXECI    = 5'd8,
    S_ALUWB    = 5'd9,
    S_BRANCH   = 5'd10,
    S_JAL      = 5'd11,
    S_JALR     = 5'd12,
    S_JALRWB   = 5'd13,
    S_LUI      = 5'd14,
    S_HALT     = 5'd15
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;

  logic       pc_write_c;
  logic       adr_src_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic [1:0] result_src_c;
  logic [1:0] alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [2:0] alu_control_c;
  logic [2:0] imm_src_c;
  logic       reg_write_c;
  logic       done_c;
  logic       illegal_flag_c;

  logic       alu_f3_ok_c;
  logic       br_f3_ok_c;
  logic       trap_c;
  logic [2:0] alu_dec_c;

  // Only func7[5] distinguishes sub from add; the other bits are don't-care.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  // Legal func3 sets for the ALU ops this core implements and for branches.
  always_comb begin
    alu_f3_ok_c = 1'b0;
    br_f3_ok_c  = 1'b0;
    case (func3)
      3'b000, 3'b111, 3'b110, 3'b100, 3'b010: alu_f3_ok_c = 1'b1;
      default:                                alu_f3_ok_c = 1'b0;
    endcase
    case (func3)
      3'b000, 3'b001, 3'b100, 3'b101: br_f3_ok_c = 1'b1;
      default:                        br_f3_ok_c = 1'b0;
    endcase
  end

  // ALU op for EXECR/EXECI; func7[5] selects sub only on register-register ops.
  always_comb begin
    alu_dec_c = ALU_ADD;
    case (func3)
      3'b000:  alu_dec_c = (state_q == S_EXECR && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec_c = ALU_AND;
      3'b110:  alu_dec_c = ALU_OR;
      3'b100:  alu_dec_c = ALU_XOR;
      3'b010:  alu_dec_c = ALU_SLT;
      default: alu_dec_c = ALU_ADD;
    endcase
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Instruction that cannot be executed; evaluated only while in DECODE.
  always_comb begin
    trap_c = 1'b0;
    if (op != OP_HALT) begin
      case (op)
        OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI: trap_c = 1'b0;
        OP_RTYPE, OP_ITYPE:                         trap_c = !alu_f3_ok_c;
        OP_BRANCH:                                  trap_c = !br_f3_ok_c;
        default:                                    trap_c = 1'b1;
      endcase
    end
  end

  // Sticky cause flag for the HALT entered through a trap.
  always_comb begin
    illegal_d = illegal_q;
    if (state_q == S_DECODE && trap_c) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_flag_c = illegal_q;
`else
  logic unused_f3_ok;
  assign unused_f3_ok   = alu_f3_ok_c ^ br_f3_ok_c;
  assign trap_c         = 1'b0;
  assign illegal_flag_c = 1'b0;
`endif

  // State and boot-counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pc_write_c    = 1'b0;
    adr_src_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    result_src_c  = RES_ALUOUT;
    alu_src_a_c   = A_PC;
    alu_src_b_c   = B_RS2;
    alu_control_c = ALU_ADD;
    imm_src_c     = IMM_I;
    reg_write_c   = 1'b0;
    done_c        = 1'b0;

    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == CNT_W'(BOOT_WAIT)) begin
          state_d = S_FETCH;
        end else begin
          boot_cnt_d = boot_cnt_q + CNT_W'(1);
        end
      end

      S_FETCH: begin
        ir_write_c   = 1'b1;
        alu_src_a_c  = A_PC;
        alu_src_b_c  = B_FOUR;
        result_src_c = RES_ALU;
        pc_write_c   = 1'b1;
        state_d      = S_DECODE;
      end

      // ALUOut captures the branch/jump target for the following state.
      S_DECODE: begin
        alu_src_a_c = A_OLDPC;
        alu_src_b_c = B_IMM;
        imm_src_c   = (op == OP_JAL) ? IMM_J : IMM_B;
        if (op == OP_HALT || trap_c) begin
          state_d = S_HALT;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECR;
            OP_ITYPE:          state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_FETCH;
          endcase
        end
      end

      S_MEMADR: begin
        alu_src_a_c = A_RS1;
        alu_src_b_c = B_IMM;
        if (op == OP_STORE) begin
          imm_src_c = IMM_S;
          state_d   = S_MEMWRITE;
        end else begin
          imm_src_c = IMM_I;
          state_d   = S_MEMREAD;
        end
      end

      S_MEMREAD: begin
        adr_src_c    = 1'b1;
        result_src_c = RES_ALUOUT;
        state_d      = S_MEMWB;
      end

      S_MEMWB: begin
        result_src_c = RES_MDR;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWRITE: begin
        adr_src_c    = 1'b1;
        result_src_c = RES_ALUOUT;
        mem_write_c  = 1'b1;
        state_d      = S_FETCH;
      end

      S_EXECR: begin
        alu_src_a_c   = A_RS1;
        alu_src_b_c   = B_RS2;
        alu_control_c = alu_dec_c;
        state_d       = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a_c   = A_RS1;
        alu_src_b_c   = B_IMM;
        imm_src_c     = IMM_I;
        alu_control_c = alu_dec_c;
        state_d       = S_ALUWB;
      end

      S_ALUWB: begin
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end

      // Compare with sub; ALUOut still holds the target from DECODE.
      S_BRANCH: begin
        alu_src_a_c   = A_RS1;
        alu_src_b_c   = B_RS2;
        alu_control_c = ALU_SUB;
        result_src_c  = RES_ALUOUT;
        case (func3)
          3'b000:  pc_write_c = zero;
          3'b001:  pc_write_c = !zero;
          3'b100:  pc_write_c = lt;
          3'b101:  pc_write_c = !lt;
          default: pc_write_c = 1'b0;
        endcase
        state_d = S_FETCH;
      end

      // PC <- target in ALUOut while ALU forms OldPC+4 for the link write.
      S_JAL: begin
        alu_src_a_c  = A_OLDPC;
        alu_src_b_c  = B_FOUR;
        result_src_c = RES_ALUOUT;
        pc_write_c   = 1'b1;
        state_d      = S_ALUWB;
      end

      S_JALR: begin
        alu_src_a_c  = A_RS1;
        alu_src_b_c  = B_IMM;
        imm_src_c    = IMM_I;
        result_src_c = RES_ALU;
        pc_write_c   = 1'b1;
        state_d      = S_JALRWB;
      end

      S_JALRWB: begin
        alu_src_a_c  = A_OLDPC;
        alu_src_b_c  = B_FOUR;
        result_src_c = RES_ALU;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end

      S_LUI: begin
        imm_src_c    = IMM_U;
        result_src_c = RES_IMM;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end

      S_HALT: begin
        done_c  = 1'b1;
        state_d = S_HALT;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Reset cycle forces every output low.
  assign PCWrite    = rst & pc_write_c;
  assign AdrSrc     = rst & adr_src_c;
  assign MemWrite   = rst & mem_write_c;
  assign IRWrite    = rst & ir_write_c;
  assign ResultSrc  = rst ? result_src_c  : 2'b00;
  assign ALUSrcA    = rst ? alu_src_a_c   : 2'b00;
  assign ALUSrcB    = rst ? alu_src_b_c   : 2'b00;
  assign ALUControl = rst ? alu_control_c : 3'b000;
  assign ImmSrc     = rst ? imm_src_c     : 3'b000;
  assign RegWrite   = rst & reg_write_c;
  assign done       = rst & done_c;
  assign illegal    = rst & done_c & illegal_flag_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (BOOT_WAIT=2, OP_HALT=0).
// Every output is packed into one control word and compared against
// hand-derived words, one per micro-step.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       lt;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [18:0] ctl;
  logic [18:0] seq [$];

  multicycle_controller #(
    .BOOT_WAIT (2),
    .OP_HALT   (7'b0000000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .func3      (func3),
    .func7      (func7),
    .zero       (zero),
    .lt         (lt),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .done       (done),
    .illegal    (illegal)
  );

  assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: pcw adr mw irw | rs a b | alu imm | rw done ill
  function automatic logic [18:0] mk(input logic pcw, input logic adr,
                                     input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] alu,
                                     input logic [2:0] imm, input logic rw,
                                     input logic dn, input logic il);
    return {pcw, adr, mw, irw, rs, a, b, alu, imm, rw, dn, il};
  endfunction

  logic [18:0] e_zero, e_fetch, e_dec_b, e_dec_j, e_aluwb, e_halt, e_halt_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk the queued control words, one per cycle, starting in the current state.
  task automatic run_seq(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z, input logic l);
    op = o; func3 = f3; func7 = f7; zero = z; lt = l;
    #1;
    for (int i = 0; i < seq.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), 32'(ctl), 32'(seq[i]));
      if (i < seq.size() - 1) tick();
    end
  endtask

  // Hold reset 3 clocks, release, expect FETCH on the 3rd edge (BOOT_WAIT=2).
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_rst_now"}, 32'(ctl), 32'(e_zero));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("%s_rst%0d", tag, i), 32'(ctl), 32'(e_zero));
    end
    rst = 1'b1;
    tick();
    check({tag, "_boot1"}, 32'(ctl), 32'(e_zero));
    tick();
    check({tag, "_boot2"}, 32'(ctl), 32'(e_zero));
    tick();
    check({tag, "_fetch1"}, 32'(ctl), 32'(e_fetch));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; op = 7'd0; func3 = 3'd0; func7 = 7'd0; zero = 1'b0; lt = 1'b0;

    e_zero     = 19'd0;
    e_fetch    = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    e_dec_b    = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0);
    e_dec_j    = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0);
    e_aluwb    = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    e_halt     = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    e_halt_ill = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1);

    do_reset("init");

    // sub: EXECR with ALUControl=001, back in FETCH on cycle 5
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0),
            e_aluwb, e_fetch};
    run_seq("sub", 7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);

    // or
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0),
            e_aluwb, e_fetch};
    run_seq("or", 7'b0110011, 3'b110, 7'b0000000, 1'b0, 1'b0);

    // slt
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0),
            e_aluwb, e_fetch};
    run_seq("slt", 7'b0110011, 3'b010, 7'b0000000, 1'b0, 1'b0);

    // andi
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0),
            e_aluwb, e_fetch};
    run_seq("andi", 7'b0010011, 3'b111, 7'b0000000, 1'b0, 1'b0);

    // addi with func7[5] set must stay add
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0),
            e_aluwb, e_fetch};
    run_seq("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0);

    // bne taken / not taken
    seq = '{e_fetch, e_dec_b,
            mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0),
            e_fetch};
    run_seq("bne_t", 7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0);
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0),
            e_fetch};
    run_seq("bne_n", 7'b1100011, 3'b001, 7'b0000000, 1'b1, 1'b0);

    // beq taken, blt taken, bge not taken
    seq = '{e_fetch, e_dec_b,
            mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0),
            e_fetch};
    run_seq("beq_t", 7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0);
    run_seq("blt_t", 7'b1100011, 3'b100, 7'b0000000, 1'b0, 1'b1);
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0),
            e_fetch};
    run_seq("bge_n", 7'b1100011, 3'b101, 7'b0000000, 1'b0, 1'b1);

    // load: MEMADR(ImmSrc I), MEMREAD(AdrSrc=1), MEMWB
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0),
            mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0),
            e_fetch};
    run_seq("lw", 7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);

    // store: MemWrite only in the 4th cycle
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0),
            mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0),
            e_fetch};
    run_seq("sw", 7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0);

    // jal
    seq = '{e_fetch, e_dec_j,
            mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0),
            e_aluwb, e_fetch};
    run_seq("jal", 7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0);

    // jalr
    seq = '{e_fetch, e_dec_b,
            mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0),
            e_fetch};
    run_seq("jalr", 7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0);

    // lui
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0),
            e_fetch};
    run_seq("lui", 7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    // illegal branch func3 traps
    seq = '{e_fetch, e_dec_b, e_halt_ill, e_halt_ill};
    run_seq("br_ill", 7'b1100011, 3'b010, 7'b0000000, 1'b1, 1'b0);
    do_reset("br_ill");
    // unknown opcode traps
    seq = '{e_fetch, e_dec_b, e_halt_ill, e_halt_ill};
    run_seq("unk", 7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0);
    do_reset("unk");
`else
    // illegal branch func3: no PC write
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0),
            e_fetch};
    run_seq("br_ill", 7'b1100011, 3'b010, 7'b0000000, 1'b1, 1'b0);
    // unknown opcode is a 2-cycle NOP
    seq = '{e_fetch, e_dec_b, e_fetch};
    run_seq("unk", 7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0);
`endif

    // reset during MEMREAD of a load aborts it
    seq = '{e_fetch, e_dec_b,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0),
            mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0)};
    run_seq("lw_abort", 7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    do_reset("abort");

    // halt: done from cycle 3, sticky
    seq = '{e_fetch, e_dec_b, e_halt};
    run_seq("halt", 7'b0000000, 3'b000, 7'b0000000, 1'b0, 1'b0);
    op = 7'b0110011;
    for (int i = 0; i < 100; i++) begin
      tick();
      check($sformatf("halt_hold%0d", i), 32'(ctl), 32'(e_halt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
